// File: rtl/adma_pkg.sv
// Shared types for the ADMA transaction dispatcher: dispatch FSM states and
// AXI burst-type encodings.
package adma_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } dsp_state_e;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2
   } axi_burst_e;

endpackage

// File: rtl/adma_ost_cnt.sv
// Per-channel outstanding-transaction counter: saturating up/down with
// full/empty flags. Blocked increments and decrements leave the count unchanged.
module adma_ost_cnt #(
   parameter int MAX_OST = 4,
   parameter int OST_W   = $clog2(MAX_OST + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic full,
   output logic empty
);

   localparam logic [OST_W-1:0] MAX_CNT = OST_W'(MAX_OST);

   logic [OST_W-1:0] cnt;
   logic             inc_ok;
   logic             dec_ok;

   assign full   = (cnt == MAX_CNT);
   assign empty  = (cnt == '0);
   assign inc_ok = inc && !full;
   assign dec_ok = dec && !empty;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // always_ff reads the pre-edge value of every register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc_ok && !dec_ok) begin
         cnt <= cnt + 1'b1;
      end else if (dec_ok && !inc_ok) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/adma_atx_dispatch.sv
// Issue controller: accepts one paired AR/AW descriptor at a time, issues both
// AXI address channels independently and tracks per-channel outstanding writes.
module adma_atx_dispatch
   import adma_pkg::*;
#(
   parameter  int DMA_CHN_NUM   = 4,
   parameter  int SRC_ADDR_W    = 32,
   parameter  int DST_ADDR_W    = 32,
   parameter  int MST_ID_W      = 5,
   parameter  int ATX_LEN_W     = 8,
   parameter  int MAX_OST       = 4,
   localparam int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM),
   localparam int OST_W         = $clog2(MAX_OST + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
   input  logic [MST_ID_W-1:0]      arid,
   input  logic [SRC_ADDR_W-1:0]    araddr,
   input  logic [ATX_LEN_W-1:0]     arlen,
   input  logic [1:0]               arburst,
   input  logic [MST_ID_W-1:0]      awid,
   input  logic [DST_ADDR_W-1:0]    awaddr,
   input  logic [ATX_LEN_W-1:0]     awlen,
   input  logic [1:0]               awburst,
   input  logic                     atx_vld,
   output logic                     atx_rdy,
   output logic [MST_ID_W-1:0]      m_arid,
   output logic [SRC_ADDR_W-1:0]    m_araddr,
   output logic [ATX_LEN_W-1:0]     m_arlen,
   output logic [1:0]               m_arburst,
   output logic                     m_arvalid,
   input  logic                     m_arready,
   output logic [MST_ID_W-1:0]      m_awid,
   output logic [DST_ADDR_W-1:0]    m_awaddr,
   output logic [ATX_LEN_W-1:0]     m_awlen,
   output logic [1:0]               m_awburst,
   output logic                     m_awvalid,
   input  logic                     m_awready,
   output logic [DMA_CHN_NUM_W-1:0] ar_chn_id,
   output logic [DMA_CHN_NUM_W-1:0] aw_chn_id,
   input  logic                     wr_cmpl_vld,
   input  logic [DMA_CHN_NUM_W-1:0] wr_cmpl_chn_id,
   output logic                     atx_done [0:DMA_CHN_NUM-1],
   output logic                     cmpl_err
);

   dsp_state_e             state;
   logic [DMA_CHN_NUM-1:0] full;
   logic [DMA_CHN_NUM-1:0] empty;
   logic [DMA_CHN_NUM-1:0] inc;
   logic [DMA_CHN_NUM-1:0] dec;
   logic                   atx_hs;
   logic                   ar_hold;
   logic                   aw_hold;

   // Ready depends on the offered channel only, never on atx_vld.
   assign atx_rdy = (state == ST_IDLE) && !full[atx_chn_id];
   assign atx_hs  = atx_vld && atx_rdy;
   assign ar_hold = m_arvalid && !m_arready;
   assign aw_hold = m_awvalid && !m_awready;

   always_comb begin
      inc = '0;
      dec = '0;
      for (int i = 0; i < DMA_CHN_NUM; i++) begin
         inc[i] = atx_hs && (atx_chn_id == DMA_CHN_NUM_W'(i));
         dec[i] = wr_cmpl_vld && (wr_cmpl_chn_id == DMA_CHN_NUM_W'(i));
      end
   end

   for (genvar g = 0; g < DMA_CHN_NUM; g++) begin : g_ost
      adma_ost_cnt #(
         .MAX_OST (MAX_OST),
         .OST_W   (OST_W)
      ) u_ost_cnt (
         .clk   (clk),
         .rst   (rst),
         .inc   (inc[g]),
         .dec   (dec[g]),
         .full  (full[g]),
         .empty (empty[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         m_arid    <= '0;
         m_araddr  <= '0;
         m_arlen   <= '0;
         m_arburst <= '0;
         m_arvalid <= 1'b0;
         m_awid    <= '0;
         m_awaddr  <= '0;
         m_awlen   <= '0;
         m_awburst <= '0;
         m_awvalid <= 1'b0;
         ar_chn_id <= '0;
         aw_chn_id <= '0;
         cmpl_err  <= 1'b0;
         for (int i = 0; i < DMA_CHN_NUM; i++) atx_done[i] <= 1'b0;
      end else begin
         // A completion on an empty channel is dropped and flagged instead.
         for (int i = 0; i < DMA_CHN_NUM; i++) atx_done[i] <= dec[i] && !empty[i];
         if (wr_cmpl_vld && empty[wr_cmpl_chn_id]) cmpl_err <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (atx_hs) begin
                  m_arid    <= arid;
                  m_araddr  <= araddr;
                  m_arlen   <= arlen;
                  m_arburst <= arburst;
                  m_awid    <= awid;
                  m_awaddr  <= awaddr;
                  m_awlen   <= awlen;
                  m_awburst <= awburst;
                  ar_chn_id <= atx_chn_id;
                  aw_chn_id <= atx_chn_id;
                  m_arvalid <= 1'b1;
                  m_awvalid <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // The valids double as the pending flags; fields hold until idle.
               if (m_arvalid && m_arready) m_arvalid <= 1'b0;
               if (m_awvalid && m_awready) m_awvalid <= 1'b0;
               if (!ar_hold && !aw_hold) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adma_atx_dispatch.sv
// Scoreboard bench: the stimulus thread drives descriptors and completions,
// a negedge monitor checks every output against a transaction-level model.
module tb_adma_atx_dispatch;

   localparam int CHN     = 4;
   localparam int MAX_OST = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  atx_chn_id = '0;
   logic [4:0]  arid = '0, awid = '0;
   logic [31:0] araddr = '0, awaddr = '0;
   logic [7:0]  arlen = '0, awlen = '0;
   logic [1:0]  arburst = '0, awburst = '0;
   logic        atx_vld = 1'b0;
   logic        atx_rdy;
   logic [4:0]  m_arid, m_awid;
   logic [31:0] m_araddr, m_awaddr;
   logic [7:0]  m_arlen, m_awlen;
   logic [1:0]  m_arburst, m_awburst;
   logic        m_arvalid, m_awvalid;
   logic        m_arready = 1'b1, m_awready = 1'b1;
   logic [1:0]  ar_chn_id, aw_chn_id;
   logic        wr_cmpl_vld = 1'b0;
   logic [1:0]  wr_cmpl_chn_id = '0;
   logic        atx_done [0:CHN-1];
   logic        cmpl_err;

   adma_atx_dispatch #(
      .DMA_CHN_NUM (CHN),
      .SRC_ADDR_W  (32),
      .DST_ADDR_W  (32),
      .MST_ID_W    (5),
      .ATX_LEN_W   (8),
      .MAX_OST     (MAX_OST)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .atx_chn_id     (atx_chn_id),
      .arid           (arid),
      .araddr         (araddr),
      .arlen          (arlen),
      .arburst        (arburst),
      .awid           (awid),
      .awaddr         (awaddr),
      .awlen          (awlen),
      .awburst        (awburst),
      .atx_vld        (atx_vld),
      .atx_rdy        (atx_rdy),
      .m_arid         (m_arid),
      .m_araddr       (m_araddr),
      .m_arlen        (m_arlen),
      .m_arburst      (m_arburst),
      .m_arvalid      (m_arvalid),
      .m_arready      (m_arready),
      .m_awid         (m_awid),
      .m_awaddr       (m_awaddr),
      .m_awlen        (m_awlen),
      .m_awburst      (m_awburst),
      .m_awvalid      (m_awvalid),
      .m_awready      (m_awready),
      .ar_chn_id      (ar_chn_id),
      .aw_chn_id      (aw_chn_id),
      .wr_cmpl_vld    (wr_cmpl_vld),
      .wr_cmpl_chn_id (wr_cmpl_chn_id),
      .atx_done       (atx_done),
      .cmpl_err       (cmpl_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: descriptors awaiting issue, per-channel outstanding counts.
   logic [48:0]    ar_q[$];
   logic [48:0]    aw_q[$];
   int             ost [CHN];
   logic [CHN-1:0] exp_done = '0;
   logic           exp_err  = 1'b0;
   logic           post_rst = 1'b0;
   logic           rand_done = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial foreach (ost[i]) ost[i] = 0;

   always @(negedge clk) begin
      logic           exp_rdy;
      logic [CHN-1:0] nd;
      exp_rdy = (ar_q.size() == 0) && (aw_q.size() == 0) && (ost[atx_chn_id] != MAX_OST);
      check("atx_rdy", atx_rdy, exp_rdy);
      check("m_arvalid", m_arvalid, ar_q.size() != 0);
      check("m_awvalid", m_awvalid, aw_q.size() != 0);
      if (ar_q.size() != 0)
         check("ar_fields", {m_arid, m_araddr, m_arlen, m_arburst, ar_chn_id}, ar_q[0]);
      if (aw_q.size() != 0)
         check("aw_fields", {m_awid, m_awaddr, m_awlen, m_awburst, aw_chn_id}, aw_q[0]);
      for (int i = 0; i < CHN; i++) check($sformatf("atx_done[%0d]", i), atx_done[i], exp_done[i]);
      check("cmpl_err", cmpl_err, exp_err);
      if (post_rst) begin
         check("reset_ar_fields", {m_arid, m_araddr, m_arlen, m_arburst, ar_chn_id}, '0);
         check("reset_aw_fields", {m_awid, m_awaddr, m_awlen, m_awburst, aw_chn_id}, '0);
      end

      // Apply what the coming rising edge will do.
      if (rst) begin
         foreach (ost[i]) ost[i] = 0;
         ar_q.delete();
         aw_q.delete();
         exp_done = '0;
         exp_err  = 1'b0;
         post_rst = 1'b1;
      end else begin
         post_rst = 1'b0;
         nd = '0;
         if (wr_cmpl_vld) begin
            if (ost[wr_cmpl_chn_id] == 0) exp_err = 1'b1;
            else begin
               ost[wr_cmpl_chn_id]--;
               nd[wr_cmpl_chn_id] = 1'b1;
            end
         end
         if (ar_q.size() != 0 && m_arready) void'(ar_q.pop_front());
         if (aw_q.size() != 0 && m_awready) void'(aw_q.pop_front());
         if (atx_vld && exp_rdy) begin
            ar_q.push_back({arid, araddr, arlen, arburst, atx_chn_id});
            aw_q.push_back({awid, awaddr, awlen, awburst, atx_chn_id});
            ost[atx_chn_id]++;
         end
         exp_done = nd;
      end
   end

   // Offer a descriptor and hold it until the DUT takes it.
   task automatic offer(input logic [1:0] chn, input logic [31:0] ra, input logic [31:0] wa,
                        input logic [7:0] rl);
      logic got;
      atx_chn_id = chn;
      arid    = 5'($urandom);
      awid    = 5'($urandom);
      araddr  = ra;
      awaddr  = wa;
      arlen   = rl;
      awlen   = 8'($urandom);
      arburst = 2'($urandom_range(0, 2));
      awburst = 2'($urandom_range(0, 2));
      atx_vld = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         got = atx_rdy;
         @(posedge clk);
         #1;
         if (got) begin
            atx_vld = 1'b0;
            return;
         end
      end
      n_vec++;
      n_err++;
      $display("FAIL offer_timeout: chn %0d got no atx_rdy in 300 cycles, required a handshake", chn);
      atx_vld = 1'b0;
   endtask

   task automatic probe(input logic [1:0] chn, input int cycles);
      atx_vld    = 1'b0;
      atx_chn_id = chn;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic cmpl(input logic [1:0] chn);
      wr_cmpl_vld    = 1'b1;
      wr_cmpl_chn_id = chn;
      @(posedge clk);
      #1;
      wr_cmpl_vld = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      probe(2'd0, 2);

      // Basic issue on ch2 with both readys high.
      offer(2'd2, 32'h0000_1000, 32'h0000_8000, 8'd15);
      probe(2'd2, 3);

      // Skewed readys: AW held off for 5 cycles.
      m_awready = 1'b0;
      offer(2'd1, 32'h0000_2000, 32'h0000_9000, 8'd3);
      repeat (5) @(posedge clk);
      #1;
      m_awready = 1'b1;
      probe(2'd1, 3);

      // Outstanding limit on ch0.
      for (int i = 0; i < MAX_OST; i++) offer(2'd0, 32'h100 * i, 32'h200 * i, 8'(i));
      probe(2'd0, 4);
      probe(2'd1, 2);
      atx_chn_id = 2'd0;
      cmpl(2'd0);
      probe(2'd0, 3);

      // Handshake and completion on ch3 in the same cycle with count 2.
      offer(2'd3, 32'h3000, 32'h3100, 8'd1);
      offer(2'd3, 32'h3200, 32'h3300, 8'd2);
      probe(2'd3, 3);
      atx_vld        = 1'b1;
      wr_cmpl_vld    = 1'b1;
      wr_cmpl_chn_id = 2'd3;
      @(posedge clk);
      #1;
      atx_vld     = 1'b0;
      wr_cmpl_vld = 1'b0;
      probe(2'd3, 3);
      offer(2'd3, 32'h3400, 32'h3500, 8'd3);
      offer(2'd3, 32'h3600, 32'h3700, 8'd4);
      probe(2'd3, 3);

      // Spurious completion on ch1 after draining it.
      cmpl(2'd1);
      cmpl(2'd1);
      probe(2'd1, 3);

      // Reset while AR is still pending.
      m_arready = 1'b0;
      offer(2'd2, 32'hDEAD_0000, 32'hBEEF_0000, 8'd7);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_arready = 1'b1;
      probe(2'd2, 3);

      // Randomized traffic with random readys and completions.
      fork
         begin
            for (int t = 0; t < 150; t++) begin
               offer(2'($urandom_range(0, 3)), $urandom, $urandom, 8'($urandom));
               if ($urandom_range(0, 3) == 0) probe(2'($urandom_range(0, 3)), 1);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               m_arready      = ($urandom_range(0, 9) < 7);
               m_awready      = ($urandom_range(0, 9) < 7);
               wr_cmpl_vld    = ($urandom_range(0, 9) < 3);
               wr_cmpl_chn_id = 2'($urandom_range(0, 3));
               @(posedge clk);
               #1;
            end
            wr_cmpl_vld = 1'b0;
            m_arready   = 1'b1;
            m_awready   = 1'b1;
         end
      join
      probe(2'd0, 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion before 500000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/adma_atx_dispatch.md
# adma_atx_dispatch

Issue controller between the AXI transaction scheduler and the AXI master ports. It accepts one arbitrated transaction (paired AR and AW descriptor) at a time and drives the AR and AW channels with independent handshakes. It enforces a per-channel outstanding-transaction limit and converts write-completion reports into per-channel `atx_done` pulses for the requesters.

## Interface
- `DMA_CHN_NUM`, 4: number of DMA channels
- `SRC_ADDR_W`, 32: AR address width
- `DST_ADDR_W`, 32: AW address width
- `MST_ID_W`, 5: AXI ID width
- `ATX_LEN_W`, 8: AXI burst length width
- `MAX_OST`, 4: maximum outstanding transactions per channel (1..15)
- `DMA_CHN_NUM_W`, `$clog2(DMA_CHN_NUM)`: derived, not set by the instantiator
- `OST_W`, `$clog2(MAX_OST+1)`: derived, not set by the instantiator

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `atx_chn_id`  in  DMA_CHN_NUM_W  channel that owns the offered transaction
- `arid`, `araddr`, `arlen`, `arburst`  in  MST_ID_W/SRC_ADDR_W/ATX_LEN_W/2  read descriptor
- `awid`, `awaddr`, `awlen`, `awburst`  in  MST_ID_W/DST_ADDR_W/ATX_LEN_W/2  write descriptor
- `atx_vld`  in  1  descriptor valid
- `atx_rdy`  out  1  descriptor accepted
- `m_arid`, `m_araddr`, `m_arlen`, `m_arburst`, `m_arvalid`  out  per field  AXI AR channel
- `m_arready`  in  1  AR ready
- `m_awid`, `m_awaddr`, `m_awlen`, `m_awburst`, `m_awvalid`  out  per field  AXI AW channel
- `m_awready`  in  1  AW ready
- `ar_chn_id`, `aw_chn_id`  out  DMA_CHN_NUM_W  owner channel, valid together with the matching valid
- `wr_cmpl_vld`  in  1  one-cycle pulse from the write-response handler: one transaction completed
- `wr_cmpl_chn_id`  in  DMA_CHN_NUM_W  channel of that completion
- `atx_done`  out  1 x [0:DMA_CHN_NUM-1]  per-channel completion pulse (unpacked array)
- `cmpl_err`  out  1  sticky flag: a completion arrived for a channel with zero outstanding transactions

## Operation
- FSM states are IDLE and ISSUE. Reset state is IDLE.
- IDLE:
  - `atx_rdy = (ost_cnt[atx_chn_id] != MAX_OST)`. The flag is combinational from `atx_chn_id` only, never from `atx_vld`.
  - A full channel blocks the scheduler head-of-line. This is intended: the scheduler must hold its offer.
- Handshake (`atx_vld && atx_rdy`):
  - register all descriptor fields and the channel ID;
  - set `ar_pend` and `aw_pend`;
  - increment `ost_cnt[chn]`;
  - go to ISSUE.
- ISSUE:
  - `atx_rdy = 0`, `m_arvalid = ar_pend`, `m_awvalid = aw_pend`.
  - Each pending flag clears on its own handshake. AR and AW may complete in either order or in the same cycle.
  - When both flags are clear at the end of a cycle, go to IDLE.
  - Once a valid is asserted, its output fields stay stable until the handshake.
- Completion:
  - `wr_cmpl_vld` decrements `ost_cnt[wr_cmpl_chn_id]` and produces a one-cycle `atx_done` pulse on that channel.
  - If the count is already 0: no decrement, no pulse, and `cmpl_err` is set.
- Simultaneous increment and completion on the same channel: the count is unchanged, and `atx_done` still pulses.
- Counters saturate at 0 and MAX_OST and never wrap.
- Reset mid-operation: all state clears immediately and pending AR/AW are dropped. Reset must be system-wide (interconnect included).

## Timing
- Reset values:
  - `atx_rdy` = 1 (all counters are 0);
  - `m_arvalid`, `m_awvalid`, every `atx_done[i]`, `cmpl_err` = 0;
  - all `m_*` fields and both channel-ID outputs = 0.
- All `m_*`, `*_chn_id`, `atx_done` and `cmpl_err` outputs are registered. Only `atx_rdy` is combinational.
- Latency:
  - `m_arvalid` and `m_awvalid` rise 1 cycle after the `atx` handshake;
  - `atx_done` rises 1 cycle after `wr_cmpl_vld`.
- Throughput: at most one transaction every 2 cycles, reached when both readys are held high.
- The counter update is visible to `atx_rdy` in the cycle after the handshake or completion.

## Structure
- A shared package `adma_pkg` holds the dispatch state enum (IDLE, ISSUE) and the AXI burst encodings (FIXED=0, INCR=1, WRAP=2).
- One sub-module, `adma_ost_cnt`: a per-channel saturating up/down counter with a full flag. It is instantiated DMA_CHN_NUM times in a generate loop.

## Test plan
- Basic issue:
  - stimulus: ch2, araddr 0x1000, awaddr 0x8000, arlen 15, both readys high;
  - response: AR and AW issued the next cycle with `*_chn_id` = 2, `ost_cnt[2]` = 1, `atx_rdy` high again 2 cycles after the handshake.
- Skewed readys:
  - stimulus: `m_awready` held low for 5 cycles while `m_arready` is high;
  - response: AR completes first, AW stays stable until its handshake, and `atx_rdy` stays 0 until the AW handshake.
- Outstanding limit:
  - stimulus: issue 4 transactions on ch0 (MAX_OST = 4) with no completions;
  - response: `atx_rdy` = 0 while `atx_chn_id` = 0 and 1 for ch1. After a `wr_cmpl` on ch0, `atx_done[0]` pulses and `atx_rdy` returns to 1.
- Simultaneous events:
  - stimulus: an `atx` handshake and `wr_cmpl_vld` for ch3 in the same cycle with `ost_cnt` = 2;
  - response: the count stays 2 and `atx_done[3]` pulses once.
- Spurious completion:
  - stimulus: `wr_cmpl_vld` on ch1 with a count of 0;
  - response: no `atx_done` pulse, `cmpl_err` = 1 until `rst`.
- Reset mid-ISSUE:
  - stimulus: assert `rst` with AR pending;
  - response: the next cycle has all valids 0, all counts 0 and `atx_rdy` = 1.
